// File: rtl/spi_reg_pkg.sv
// Shared types and frame-geometry helpers for the SPI register bank.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } spi_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // One R/W bit, then address, then data, MSB first.
  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

  // R/W lands in the top bit of the shift register once a full frame is in.
  function automatic int unsigned rw_pos(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between a controller and the register bank.
interface spi_reg_bank_if;
  logic sclk;
  logic cs_n;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (
    output sclk,
    output cs_n,
    output copi,
    input  cipo,
    input  cipo_oe
  );

  modport slave (
    input  sclk,
    input  cs_n,
    input  copi,
    output cipo,
    output cipo_oe
  );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous input bit.
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank, fully clk-domain: writes commit only on well-formed frames,
// reads stream the addressed register back on cipo.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned        NUM_REGS    = 5,
  parameter int unsigned        DATA_W      = 8,
  parameter int unsigned        ADDR_W      = 7,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  spi_reg_bank_if.slave              spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_stb,
  output logic                       frame_err
);

  localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int unsigned RW_POS  = rw_pos(ADDR_W, DATA_W);
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned AW1     = ADDR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(1 + ADDR_W);
  localparam logic [AW1-1:0]   NREGS_W  = AW1'(NUM_REGS);

  logic sclk_s, cs_s, copi_s;
  logic sclk_q, cs_q;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi.sclk),
    .q     (sclk_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi.cs_n),
    .q     (cs_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (spi.copi),
    .q     (copi_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;

  spi_state_e                       state_q, state_d;
  logic [CNT_W-1:0]                 bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0]               sr_q, sr_d;
  logic                             ovr_q, ovr_d;
  logic [DATA_W-1:0]                tx_q, tx_d;
  logic                             rd_q, rd_d;
  logic                             pend_q, pend_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
  logic [NUM_REGS-1:0]              wr_stb_q, wr_stb_d;
  logic                             frame_err_q, frame_err_d;

  logic [FRAME_W-1:0] shift_in;
  logic [DATA_W-1:0]  rd_val;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cmd_data;
  logic               cmd_rw;
  logic               frame_ok;

  assign shift_in = {sr_q[FRAME_W-2:0], copi_s};
  assign cmd_rw   = sr_q[RW_POS];
  assign cmd_addr = sr_q[DATA_W +: ADDR_W];
  assign cmd_data = sr_q[DATA_W-1:0];
  assign frame_ok = (bit_cnt_q == CNT_FULL) && !ovr_q;

  // Read lookup uses the address as it stands after the header's last bit shifts in.
  always_comb begin
    rd_val = '0;
    if ({1'b0, shift_in[ADDR_W-1:0]} < NREGS_W) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (shift_in[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    ovr_d       = ovr_q;
    tx_d        = tx_q;
    rd_d        = rd_q;
    pend_d      = pend_q;
    regs_d      = regs_q;
    wr_stb_d    = '0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall || pend_q) begin
          state_d   = StShift;
          bit_cnt_d = '0;
          sr_d      = '0;
          ovr_d     = 1'b0;
          tx_d      = '0;
          rd_d      = 1'b0;
          pend_d    = 1'b0;
        end
      end
      StShift: begin
        if (cs_rise) begin
          state_d = StDone;
        end else if (sclk_rise) begin
          sr_d = shift_in;
          if (bit_cnt_q == CNT_FULL) begin
            ovr_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (bit_cnt_q == CNT_HDR && shift_in[ADDR_W] == RW_READ) begin
            tx_d = rd_val;
            rd_d = 1'b1;
          end
        end else if (sclk_fall && rd_q && bit_cnt_q > CNT_DATA) begin
          // The fall right after the load keeps the MSB up for the first data rise.
          tx_d = {tx_q[DATA_W-2:0], 1'b0};
        end
      end
      StDone: begin
        state_d = StIdle;
        rd_d    = 1'b0;
        if (cs_fall) pend_d = 1'b1;
        if (!frame_ok) begin
          frame_err_d = 1'b1;
        end else if (cmd_rw == RW_WRITE && {1'b0, cmd_addr} < NREGS_W) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr == ADDR_W'(i)) begin
              regs_d[i]   = cmd_data;
              wr_stb_d[i] = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      ovr_q       <= 1'b0;
      tx_q        <= '0;
      rd_q        <= 1'b0;
      pend_q      <= 1'b0;
      regs_q      <= {NUM_REGS{RESET_VAL}};
      wr_stb_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      ovr_q       <= ovr_d;
      tx_q        <= tx_d;
      rd_q        <= rd_d;
      pend_q      <= pend_d;
      regs_q      <= regs_d;
      wr_stb_q    <= wr_stb_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign regs_flat   = regs_q;
  assign wr_stb      = wr_stb_q;
  assign frame_err   = frame_err_q;
  assign spi.cipo    = (rd_q && state_q == StShift) ? tx_q[DATA_W-1] : 1'b0;
  assign spi.cipo_oe = ~cs_s;

endmodule
